// File: rtl/compressor_pkg.sv
// Shared definitions for the float32 compression path: element class
// encodings, packer FSM states, default parameters and class sizes.
package compressor_pkg;

    // Two-bit element class as it appears in the block bitmap.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'b00,   // payload dropped entirely
        CLS_8    = 2'b01,   // 8-bit compressed payload
        CLS_16   = 2'b10,   // 16-bit compressed payload
        CLS_32   = 2'b11    // raw float32
    } cls_e;

    // Packer block states.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,   // accepting elements
        ST_FLUSH = 2'b01,   // draining partial words of the finished block
        ST_BMAP  = 2'b10    // presenting the block bitmap
    } pkr_state_e;

    localparam int DEF_OUT_BYTES = 8;
    localparam int DEF_BLOCK_LEN = 16;
    localparam int DEF_TH0       = 112;
    localparam int DEF_TH1       = 120;
    localparam int DEF_TH2       = 127;

    // Number of payload bytes an element of the given class contributes.
    function automatic logic [2:0] cls_len(input cls_e c);
        logic [2:0] len;
        case (c)
            CLS_8:   len = 3'd1;
            CLS_16:  len = 3'd2;
            CLS_32:  len = 3'd4;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/compressor_class.sv
// Combinational element classifier plus the two narrow float compressors
// it relies on. Payloads come out right-aligned and zero-extended to 32 bits.

// 16-bit compressor: bfloat16 by truncation (sign, full exponent, top 7
// mantissa bits). Class-10 values keep their exponent exactly.
module compressor_16 (
    input  logic [31:0] in_data,
    output logic [15:0] out_data
);
    logic unused_lo;

    assign out_data  = in_data[31:16];
    assign unused_lo = ^in_data[15:0];
endmodule

// 8-bit compressor: sign, low 3 exponent bits, top 4 mantissa bits.
// Class-01 exponents lie in a window of at most 8 values starting at a
// multiple of 8 (120..126 by default), so the low 3 bits identify them.
module compressor_8 (
    input  logic [31:0] in_data,
    output logic [7:0]  out_data
);
    logic unused_bits;

    assign out_data    = {in_data[31], in_data[25:23], in_data[22:19]};
    assign unused_bits = ^{in_data[30:26], in_data[18:0]};
endmodule

module compressor_class
    import compressor_pkg::*;
#(
    parameter int TH0 = DEF_TH0,
    parameter int TH1 = DEF_TH1,
    parameter int TH2 = DEF_TH2
) (
    input  logic [31:0] in_data,
    input  logic        bypass,
    output cls_e        cls,
    output logic [2:0]  len,
    output logic [31:0] payload
);
    localparam logic [7:0] T0 = 8'(TH0);
    localparam logic [7:0] T1 = 8'(TH1);
    localparam logic [7:0] T2 = 8'(TH2);

    logic [7:0]  exp_w;
    logic [15:0] c16;
    logic [7:0]  c8;

    assign exp_w = in_data[30:23];

    compressor_16 u_c16 (
        .in_data  (in_data),
        .out_data (c16)
    );

    compressor_8 u_c8 (
        .in_data  (in_data),
        .out_data (c8)
    );

    // Exponent thresholds pick the class; Inf/NaN (exp 255) land in CLS_32.
    always_comb begin
        cls = CLS_ZERO;
        if (bypass || exp_w >= T2) begin
            cls = CLS_32;
        end else if (exp_w >= T1) begin
            cls = CLS_8;
        end else if (exp_w >= T0) begin
            cls = CLS_16;
        end
    end

    // Select the payload for the chosen class, unused upper bytes zero.
    always_comb begin
        payload = 32'h0;
        case (cls)
            CLS_32:  payload = in_data;
            CLS_16:  payload = {16'h0, c16};
            CLS_8:   payload = {24'h0, c8};
            default: payload = 32'h0;
        endcase
    end

    assign len = cls_len(cls);

endmodule

// File: rtl/compressor_packer.sv
// Streaming float32 compressor/packer. Classifies each element, appends its
// variable-length payload little-endian into a two-word accumulator, emits
// fixed-width words, and at each block end flushes and emits the bitmap.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and data stable until the transfer;
// ready may change freely and never depends combinationally on its own valid.
module compressor_packer
    import compressor_pkg::*;
#(
    parameter int OUT_BYTES = DEF_OUT_BYTES,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN,
    parameter int TH0       = DEF_TH0,
    parameter int TH1       = DEF_TH1,
    parameter int TH2       = DEF_TH2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_bypass,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [31:0]                        in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [8*OUT_BYTES-1:0]             out_data,
    output logic                               bm_valid,
    input  logic                               bm_ready,
    output logic [2*BLOCK_LEN-1:0]             bm_data,
    output logic [$clog2(BLOCK_LEN+1)-1:0]     bm_count,
    output logic [$clog2(4*BLOCK_LEN+1)-1:0]   bm_bytes
);
    localparam int ACC_BYTES = 2 * OUT_BYTES;
    localparam int ACC_W     = 8 * ACC_BYTES;
    localparam int OUT_W     = 8 * OUT_BYTES;
    localparam int FILL_W    = $clog2(ACC_BYTES + 1);
    localparam int CNT_W     = $clog2(BLOCK_LEN + 1);
    localparam int BYT_W     = $clog2(4 * BLOCK_LEN + 1);

    localparam logic [FILL_W-1:0] FILL_WORD   = FILL_W'(OUT_BYTES);
    localparam logic [FILL_W-1:0] FILL_IN_MAX = FILL_W'(ACC_BYTES - 4);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(BLOCK_LEN - 1);

    pkr_state_e               state_q, state_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2*BLOCK_LEN-1:0]   bm_q, bm_d;
    logic [BYT_W-1:0]         bytes_q, bytes_d;
    logic                     bypass_q, bypass_d;

    cls_e                     el_cls;
    logic [2:0]               el_len;
    logic [31:0]              el_payload;
    logic                     el_bypass;

    logic                     accept;
    logic                     out_free;
    logic                     do_load;
    logic [ACC_W-1:0]         acc_shift;
    logic [FILL_W-1:0]        fill_shift;
    logic [OUT_W-1:0]         load_word;

    // Bypass is latched with the first element so it stays fixed for a block.
    assign el_bypass = (cnt_q == '0) ? cfg_bypass : bypass_q;

    compressor_class #(
        .TH0 (TH0),
        .TH1 (TH1),
        .TH2 (TH2)
    ) u_class (
        .in_data (in_data),
        .bypass  (el_bypass),
        .cls     (el_cls),
        .len     (el_len),
        .payload (el_payload)
    );

    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;
    assign do_load  = out_free &&
                      ((fill_q >= FILL_WORD) || (state_q == ST_FLUSH && fill_q != '0));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: block end on last/full, bitmap once everything drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && (in_last || cnt_q == CNT_LAST)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fill_q == '0 && !out_valid_q) begin
                    state_d = ST_BMAP;
                end
            end
            ST_BMAP: begin
                if (bm_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: input ready only in RUN with room for a full 4-byte payload.
    always_comb begin
        in_ready = 1'b0;
        bm_valid = 1'b0;
        case (state_q)
            ST_RUN:  in_ready = (fill_q <= FILL_IN_MAX) && !rst;
            ST_BMAP: bm_valid = !rst;
            default: ;
        endcase
    end

    // Accumulator and out register: shift out a word first, then append.
    always_comb begin
        load_word = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (FILL_W'(i) < fill_q) begin
                load_word[8*i +: 8] = acc_q[8*i +: 8];
            end
        end

        acc_shift  = acc_q;
        fill_shift = fill_q;
        if (do_load) begin
            acc_shift  = acc_q >> OUT_W;
            fill_shift = (fill_q >= FILL_WORD) ? (fill_q - FILL_WORD) : '0;
        end

        acc_d  = acc_shift;
        fill_d = fill_shift;
        if (accept) begin
            acc_d  = acc_shift | (ACC_W'(el_payload) << {fill_shift, 3'b000});
            fill_d = fill_shift + FILL_W'(el_len);
        end

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (do_load) begin
            out_data_d  = load_word;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Block bookkeeping: element count, bitmap and unpadded byte total.
    always_comb begin
        cnt_d    = cnt_q;
        bm_d     = bm_q;
        bytes_d  = bytes_q;
        bypass_d = bypass_q;
        if (accept) begin
            cnt_d   = cnt_q + CNT_W'(1);
            bytes_d = bytes_q + BYT_W'(el_len);
            for (int i = 0; i < BLOCK_LEN; i++) begin
                if (CNT_W'(i) == cnt_q) begin
                    bm_d[2*i +: 2] = el_cls;
                end
            end
            if (cnt_q == '0) begin
                bypass_d = cfg_bypass;
            end
        end
        if (bm_valid && bm_ready) begin
            cnt_d   = '0;
            bm_d    = '0;
            bytes_d = '0;
        end
    end

    // Datapath registers; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            bm_q        <= '0;
            bytes_q     <= '0;
            bypass_q    <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            bm_q        <= bm_d;
            bytes_q     <= bytes_d;
            bypass_q    <= bypass_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign bm_data   = bm_q;
    assign bm_count  = cnt_q;
    assign bm_bytes  = bytes_q;

endmodule

// File: tb/tb_compressor_packer.sv
// Bench for compressor_packer with default parameters: directed blocks,
// backpressure, bypass, mid-block reset and a randomised phase.
module tb_compressor_packer;

    localparam int OB = 8;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_bypass;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        bm_valid;
    logic        bm_ready;
    logic [31:0] bm_data;
    logic [4:0]  bm_count;
    logic [6:0]  bm_bytes;

    compressor_packer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_bypass (cfg_bypass),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bm_valid   (bm_valid),
        .bm_ready   (bm_ready),
        .bm_data    (bm_data),
        .bm_count   (bm_count),
        .bm_bytes   (bm_bytes)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [31:0] exp_bm_q[$];
    logic [4:0]  exp_cnt_q[$];
    logic [6:0]  exp_byt_q[$];

    logic [7:0]  mdl_bytes[$];
    int          mdl_cnt = 0;
    logic [31:0] mdl_bm = '0;
    int          mdl_tot = 0;
    logic        mdl_byp = 1'b0;
    int          n_accepted = 0;

    function automatic logic [1:0] mdl_cls(input logic [31:0] d, input logic byp);
        int e;
        e = int'(d[30:23]);
        if (byp || e >= 127) return 2'b11;
        if (e >= 120) return 2'b01;
        if (e >= 112) return 2'b10;
        return 2'b00;
    endfunction

    task automatic mdl_word(input bit pad);
        logic [63:0] w;
        while (mdl_bytes.size() >= OB || (pad && mdl_bytes.size() > 0)) begin
            w = '0;
            for (int k = 0; k < OB; k++) begin
                if (mdl_bytes.size() > 0) w[8*k +: 8] = mdl_bytes.pop_front();
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic mdl_accept(input logic [31:0] d, input logic last);
        logic [1:0]  c;
        logic [15:0] h;
        if (mdl_cnt == 0) mdl_byp = cfg_bypass;
        c = mdl_cls(d, mdl_byp);
        case (c)
            2'b11: begin
                for (int k = 0; k < 4; k++) mdl_bytes.push_back(d[8*k +: 8]);
                mdl_tot += 4;
            end
            2'b10: begin
                h = d[31:16];
                mdl_bytes.push_back(h[7:0]);
                mdl_bytes.push_back(h[15:8]);
                mdl_tot += 2;
            end
            2'b01: begin
                mdl_bytes.push_back({d[31], d[25:23], d[22:19]});
                mdl_tot += 1;
            end
            default: ;
        endcase
        mdl_bm[2*mdl_cnt +: 2] = c;
        mdl_cnt++;
        n_accepted++;
        mdl_word(1'b0);
        if (last || mdl_cnt == BL) begin
            mdl_word(1'b1);
            exp_bm_q.push_back(mdl_bm);
            exp_cnt_q.push_back(5'(mdl_cnt));
            exp_byt_q.push_back(7'(mdl_tot));
            mdl_cnt = 0;
            mdl_bm  = '0;
            mdl_tot = 0;
        end
    endtask

    task automatic mdl_clear();
        exp_q.delete();
        exp_bm_q.delete();
        exp_cnt_q.delete();
        exp_byt_q.delete();
        mdl_bytes.delete();
        mdl_cnt = 0;
        mdl_bm  = '0;
        mdl_tot = 0;
    endtask

    // ---------------- monitor ----------------
    int          n_words = 0;
    logic [63:0] last_word;
    logic [31:0] last_bm;
    logic [6:0]  last_bytes;
    logic [4:0]  last_cnt;
    logic        prev_out_stall = 1'b0;
    logic [63:0] prev_out;
    logic        prev_bm_stall = 1'b0;
    logic [31:0] prev_bm;

    always @(negedge clk) begin
        if (rst) begin
            prev_out_stall = 1'b0;
            prev_bm_stall  = 1'b0;
        end else begin
            if (prev_out_stall) begin
                chk("out_valid_hold", 64'(out_valid), 64'd1);
                chk("out_data_hold", out_data, prev_out);
            end
            if (prev_bm_stall) begin
                chk("bm_valid_hold", 64'(bm_valid), 64'd1);
                chk("bm_data_hold", 64'(bm_data), 64'(prev_bm));
            end
            if (out_valid && out_ready) begin
                n_words++;
                last_word = out_data;
                if (exp_q.size() == 0) chk("word_expected", 64'(exp_q.size()), 64'd1);
                else chk("word", out_data, exp_q.pop_front());
            end
            if (bm_valid && bm_ready) begin
                last_bm    = bm_data;
                last_bytes = bm_bytes;
                last_cnt   = bm_count;
                chk("bm_after_words", 64'(exp_q.size()), 64'd0);
                if (exp_bm_q.size() == 0) begin
                    chk("bm_expected", 64'(exp_bm_q.size()), 64'd1);
                end else begin
                    chk("bm_data", 64'(bm_data), 64'(exp_bm_q.pop_front()));
                    chk("bm_count", 64'(bm_count), 64'(exp_cnt_q.pop_front()));
                    chk("bm_bytes", 64'(bm_bytes), 64'(exp_byt_q.pop_front()));
                end
            end
            prev_out_stall = out_valid && !out_ready;
            prev_out       = out_data;
            prev_bm_stall  = bm_valid && !bm_ready;
            prev_bm        = bm_data;
        end
    end

    // ---------------- driver tasks ----------------
    bit rnd_en = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) begin
                out_ready = ($urandom_range(0, 3) != 0);
                bm_ready  = ($urandom_range(0, 1) != 0);
            end
        end
    end

    task automatic send_elem(input logic [31:0] d, input logic last);
        int w;
        w = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 2000) break;
        end
        if (w > 2000) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            mdl_accept(d, last);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp_bm_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("drain_left", 64'(exp_q.size() + exp_bm_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_bm_valid", 64'(bm_valid), 64'd0);
        chk("rst_bm_data", 64'(bm_data), 64'd0);
        chk("rst_bm_count", 64'(bm_count), 64'd0);
        chk("rst_bm_bytes", 64'(bm_bytes), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        mdl_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_elem();
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(0, 111));
            1:       e = 8'($urandom_range(112, 119));
            2:       e = 8'($urandom_range(120, 126));
            default: e = 8'($urandom_range(127, 255));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int base_words;
    int base_acc;

    initial begin
        rst        = 1'b1;
        cfg_bypass = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        bm_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // all class 11
        base_words = n_words;
        for (int i = 0; i < BL; i++) send_elem(32'h3F800000, 1'b0);
        drain();
        chk("t1_words", 64'(n_words - base_words), 64'd8);
        chk("t1_word_val", last_word, 64'h3F8000003F800000);
        chk("t1_bm", 64'(last_bm), 64'hFFFFFFFF);
        chk("t1_cnt", 64'(last_cnt), 64'd16);
        chk("t1_bytes", 64'(last_bytes), 64'd64);

        // all class 00
        base_words = n_words;
        for (int i = 0; i < BL; i++) send_elem(32'h00000000, 1'b0);
        drain();
        chk("t2_words", 64'(n_words - base_words), 64'd0);
        chk("t2_bm", 64'(last_bm), 64'd0);
        chk("t2_cnt", 64'(last_cnt), 64'd16);
        chk("t2_bytes", 64'(last_bytes), 64'd0);

        // short block ended by in_last
        base_words = n_words;
        send_elem(32'h3F800000, 1'b0);
        send_elem(32'h3A800000, 1'b1);
        drain();
        chk("t3_words", 64'(n_words - base_words), 64'd1);
        chk("t3_word_val", last_word, 64'h00003A803F800000);
        chk("t3_bm", 64'(last_bm), 64'h0000000B);
        chk("t3_cnt", 64'(last_cnt), 64'd2);
        chk("t3_bytes", 64'(last_bytes), 64'd6);

        // output backpressure
        base_words = n_words;
        base_acc   = n_accepted;
        out_ready  = 1'b0;
        fork
            begin
                for (int i = 0; i < BL; i++) send_elem(32'h3F800000 + 32'(i), 1'b0);
            end
            begin
                repeat (20) @(negedge clk);
                chk("t4_stall_in_ready", 64'(in_ready), 64'd0);
                chk("t4_stall_accepted", 64'(n_accepted - base_acc), 64'd6);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t4_words", 64'(n_words - base_words), 64'd8);

        // bypass forces class 11
        base_words = n_words;
        cfg_bypass = 1'b1;
        for (int i = 0; i < BL; i++) send_elem(32'h00000000, 1'b0);
        drain();
        cfg_bypass = 1'b0;
        chk("t5_words", 64'(n_words - base_words), 64'd8);
        chk("t5_word_val", last_word, 64'd0);
        chk("t5_bm", 64'(last_bm), 64'hFFFFFFFF);
        chk("t5_bytes", 64'(last_bytes), 64'd64);

        // reset mid-block, then a class-01 block
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_elem(32'h3F800000, 1'b0);
        do_reset();
        out_ready  = 1'b1;
        base_words = n_words;
        for (int i = 0; i < BL; i++) send_elem({1'b0, 8'd123, 23'($urandom)}, 1'b0);
        drain();
        chk("t6_words", 64'(n_words - base_words), 64'd2);
        chk("t6_bm", 64'(last_bm), 64'h55555555);
        chk("t6_bytes", 64'(last_bytes), 64'd16);

        // randomised mix with random readiness
        rnd_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            cfg_bypass = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < BL; i++) begin
                if ($urandom_range(0, 9) == 0 || i == BL - 1) begin
                    send_elem(rnd_elem(), ($urandom_range(0, 1) == 1));
                    break;
                end
                send_elem(rnd_elem(), 1'b0);
            end
        end
        // make sure any open block closes
        if (mdl_cnt != 0) send_elem(rnd_elem(), 1'b1);
        drain();
        rnd_en    = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        bm_ready  = 1'b1;
        drain();

        chk("left_words", 64'(exp_q.size()), 64'd0);
        chk("left_bm", 64'(exp_bm_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
